// File: rtl/gemm_index_gen_if.sv
// Bundle, micro-op SRAM and index-triple signals of the GEMM index generator.
// slave is the generator's view; master is the surrounding producer/SRAM/consumer.
interface gemm_index_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] upc;
    logic [10:0] dst_offset_out;
    logic [10:0] dst_offset_in;
    logic [10:0] src_offset_out;
    logic [10:0] src_offset_in;
    logic [9:0]  wgt_offset_out;
    logic [9:0]  wgt_offset_in;

    logic        uop_rd_en;
    logic [12:0] uop_rd_addr;
    logic [31:0] uop_rd_data;

    logic        out_valid;
    logic        out_ready;
    logic [10:0] acc_idx;
    logic [10:0] inp_idx;
    logic [9:0]  wgt_idx;

    modport slave (
        input  in_valid, upc,
        input  dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
        input  wgt_offset_out, wgt_offset_in,
        input  uop_rd_data, out_ready,
        output in_ready, uop_rd_en, uop_rd_addr,
        output out_valid, acc_idx, inp_idx, wgt_idx
    );

    modport master (
        output in_valid, upc,
        output dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
        output wgt_offset_out, wgt_offset_in,
        output uop_rd_data, out_ready,
        input  in_ready, uop_rd_en, uop_rd_addr,
        input  out_valid, acc_idx, inp_idx, wgt_idx
    );
endinterface

// File: rtl/gemm_index_gen.sv
// GEMM index generator: reads a micro-op, adds pre-summed loop offsets to its
// three fields and queues the resulting index triple in a 3-entry output FIFO.
module gemm_index_gen #(
    parameter int FIFO_DEPTH = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             clear,
    gemm_index_gen_if.slave bus
);

    typedef struct packed {
        logic [9:0]  wgt;
        logic [10:0] inp;
        logic [10:0] acc;
    } triple_t;

    // Stage 1: offsets summed while the micro-op SRAM read is in flight.
    logic        s1_valid;
    logic [10:0] dst_sum;
    logic [10:0] src_sum;
    logic [9:0]  wgt_sum;

    // Output FIFO; pointers wrap at FIFO_DEPTH (fixed at 3, so 2-bit fields).
    triple_t     mem [FIFO_DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [1:0]  fifo_count;

    logic        accept;
    logic        push;
    logic        pop;
    triple_t     push_data;
    triple_t     head;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Occupancy counts the stage-1 slot as committed, so a downstream stall can
    // never overrun the FIFO; out_ready deliberately does not appear here.
    assign bus.in_ready = !rst && !clear &&
                          ((3'(s1_valid) + 3'(fifo_count)) < 3'(FIFO_DEPTH));
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.uop_rd_en   = accept;
    assign bus.uop_rd_addr = bus.upc;

    assign push = s1_valid;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        push_data     = '0;
        push_data.acc = bus.uop_rd_data[10:0]  + dst_sum;
        push_data.inp = bus.uop_rd_data[21:11] + src_sum;
        push_data.wgt = bus.uop_rd_data[31:22] + wgt_sum;
    end

    assign head          = mem[rd_ptr];
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.acc_idx   = head.acc;
    assign bus.inp_idx   = head.inp;
    assign bus.wgt_idx   = head.wgt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make the result order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            dst_sum  <= '0;
            src_sum  <= '0;
            wgt_sum  <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                dst_sum <= bus.dst_offset_out + bus.dst_offset_in;
                src_sum <= bus.src_offset_out + bus.src_offset_in;
                wgt_sum <= bus.wgt_offset_out + bus.wgt_offset_in;
            end
        end
    end

    // NOTE: the storage is reset on purpose: the head entry drives the index
    // outputs directly, and those must read 0 while rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 2'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_gemm_index_gen.sv
// Bench for gemm_index_gen: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_gemm_index_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gemm_index_gen_if bus ();

    gemm_index_gen #(.FIFO_DEPTH(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    // Micro-op SRAM with a fixed one-cycle read latency.
    logic [31:0] sram [8192];
    always @(posedge clk) begin
        if (bus.uop_rd_en) bus.uop_rd_data <= sram[bus.uop_rd_addr];
    end

    typedef struct {
        logic [10:0] acc;
        logic [10:0] inp;
        logic [9:0]  wgt;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cnt = 0;
    int   pop_first = 0;
    int   pop_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each index is the SRAM field plus both offsets, reduced modulo the field range.
    function automatic exp_t model_triple(input int a, input int dso, input int dsi,
                                          input int sso, input int ssi,
                                          input int wso, input int wsi, input int due);
        exp_t e;
        logic [31:0] w;
        w     = sram[a];
        e.acc = 11'((int'(w[10:0])  + dso + dsi) % 2048);
        e.inp = 11'((int'(w[21:11]) + sso + ssi) % 2048);
        e.wgt = 10'((int'(w[31:22]) + wso + wsi) % 1024);
        e.due = due;
        return e;
    endfunction

    // Reference model and compare process; the queue holds every accepted
    // bundle not yet consumed, so its length is the block's occupancy.
    always @(negedge clk) begin
        bit exp_ov;
        bit exp_rdy;
        bit overflow;
        if (rst) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_acc_idx", bus.acc_idx, 0);
            check("rst_inp_idx", bus.inp_idx, 0);
            check("rst_wgt_idx", bus.wgt_idx, 0);
            exp_q.delete();
        end else begin
            exp_ov  = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            exp_rdy = !clear && (exp_q.size() < 3);
            check("out_valid", bus.out_valid, exp_ov);
            check("in_ready", bus.in_ready, exp_rdy);
            check("uop_rd_en", bus.uop_rd_en, bus.in_valid && exp_rdy);
            if (exp_ov) begin
                check("acc_idx", bus.acc_idx, exp_q[0].acc);
                check("inp_idx", bus.inp_idx, exp_q[0].inp);
                check("wgt_idx", bus.wgt_idx, exp_q[0].wgt);
            end
            overflow = dut.s1_valid && (dut.fifo_count == 2'd3) &&
                       !(bus.out_valid && bus.out_ready);
            check("no_overflow_push", overflow, 0);
            if (clear) begin
                exp_q.delete();
            end else begin
                if (exp_ov && bus.out_ready) begin
                    void'(exp_q.pop_front());
                    if (pop_cnt == 0) pop_first = cyc;
                    pop_last = cyc;
                    pop_cnt++;
                end
                if (bus.in_valid && exp_rdy) begin
                    check("uop_rd_addr", bus.uop_rd_addr, bus.upc);
                    exp_q.push_back(model_triple(bus.upc, bus.dst_offset_out, bus.dst_offset_in,
                                                 bus.src_offset_out, bus.src_offset_in,
                                                 bus.wgt_offset_out, bus.wgt_offset_in, cyc + 2));
                end
            end
        end
    end

    task automatic drive(input int a, input int dso, input int dsi, input int sso,
                         input int ssi, input int wso, input int wsi);
        bus.in_valid       = 1'b1;
        bus.upc            = 13'(a);
        bus.dst_offset_out = 11'(dso);
        bus.dst_offset_in  = 11'(dsi);
        bus.src_offset_out = 11'(sso);
        bus.src_offset_in  = 11'(ssi);
        bus.wgt_offset_out = 10'(wso);
        bus.wgt_offset_in  = 10'(wsi);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepts;
        int start;

        for (int i = 0; i < 8192; i++) sram[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        sram[5] = {10'd3, 11'd7, 11'd9};
        sram[6] = {10'd1023, 11'd0, 11'd2047};

        clear         = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) next_cycle();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_acc_idx", bus.acc_idx, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        // Single op: 9+18=27, 7+33=40, 3+4=7, visible two edges after transfer.
        next_cycle();
        drive(5, 16, 2, 32, 1, 4, 0);
        next_cycle();
        bus.in_valid = 1'b0;
        check("single_lat1_out_valid", bus.out_valid, 0);
        next_cycle();
        check("single_out_valid", bus.out_valid, 1);
        check("single_acc_idx", bus.acc_idx, 27);
        check("single_inp_idx", bus.inp_idx, 40);
        check("single_wgt_idx", bus.wgt_idx, 7);

        // Wrap: 2047+1+1 -> 1 and 1023+0+2 -> 1.
        next_cycle();
        drive(6, 1, 1, 0, 0, 0, 2);
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        check("wrap_out_valid", bus.out_valid, 1);
        check("wrap_acc_idx", bus.acc_idx, 1);
        check("wrap_inp_idx", bus.inp_idx, 0);
        check("wrap_wgt_idx", bus.wgt_idx, 1);

        // Offset sums that themselves overflow their field width.
        drive(7, 2047, 2, 1500, 1000, 1000, 100);
        next_cycle();
        drive(6, 2047, 2047, 2047, 2047, 1023, 1023);
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (4) next_cycle();

        // Backpressure: exactly three accepts, then drain in order.
        bus.out_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            drive(100 + i, i, 3 * i, 2 * i, 5, i, 1);
            if (bus.in_ready) accepts++;
            next_cycle();
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", accepts, 3);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_fifo_count", dut.fifo_count, 3);
        pop_cnt = 0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10 && pop_cnt < 3; t++) next_cycle();
        check("bp_drained", pop_cnt, 3);
        repeat (2) next_cycle();
        check("bp_no_duplicate", bus.out_valid, 0);

        // Streaming: 100 back-to-back bundles with the consumer always ready.
        pop_cnt = 0;
        start = cyc;
        for (int i = 0; i < 100; i++) begin
            drive(200 + i, i, 7, 2 * i, 3, i % 64, 9);
            check("stream_in_ready", bus.in_ready, 1);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 10 && pop_cnt < 100; t++) next_cycle();
        check("stream_count", pop_cnt, 100);
        check("stream_first_cycle", pop_first - start, 2);
        check("stream_consecutive", pop_last - pop_first, 99);

        // Clear with two queued, one in stage 1, and a simultaneous pop.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(400 + i, i, 1, i, 2, i, 3);
            next_cycle();
        end
        check("clr_setup_count", dut.fifo_count, 2);
        check("clr_setup_s1", dut.s1_valid, 1);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        drive(410, 1, 1, 1, 1, 1, 1);
        #1;
        check("clr_in_ready", bus.in_ready, 0);
        check("clr_uop_rd_en", bus.uop_rd_en, 0);
        next_cycle();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("clr_out_valid", bus.out_valid, 0);
        check("clr_in_ready_after", bus.in_ready, 1);
        repeat (5) next_cycle();

        // Reset pulse with three triples pending.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(500 + i, i, 4, i, 4, i, 4);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        check("rstmid_setup_count", dut.fifo_count, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rstmid_out_valid", bus.out_valid, 0);
        check("rstmid_in_ready", bus.in_ready, 0);
        check("rstmid_acc_idx", bus.acc_idx, 0);
        next_cycle();
        check("rstmid_in_ready_held", bus.in_ready, 0);
        next_cycle();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rstmid_in_ready_release", bus.in_ready, 1);
        next_cycle();
        drive(5, 16, 2, 32, 1, 4, 0);
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        check("post_rst_out_valid", bus.out_valid, 1);
        check("post_rst_acc_idx", bus.acc_idx, 27);
        check("post_rst_inp_idx", bus.inp_idx, 40);
        check("post_rst_wgt_idx", bus.wgt_idx, 7);
        repeat (4) next_cycle();
        check("post_rst_idle", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemm_index_gen.md
GEMM_INDEX_GEN -- requirements
Module: gemm_index_gen

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 3: output buffer entries; fixed at 3, other values unsupported.
REQ-002 SHALL have port clk, input, 1: system clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port clear, input, 1: synchronous flush of all in-flight work.
REQ-005 SHALL have port in_valid, input, 1: upc/offset bundle valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts bundle this cycle.
REQ-007 SHALL have port upc, input, 13: micro-op address.
REQ-008 SHALL have ports dst_offset_out, dst_offset_in, src_offset_out and src_offset_in, each input, 11: loop offsets.
REQ-009 SHALL have ports wgt_offset_out and wgt_offset_in, each input, 10: loop offsets.
REQ-010 SHALL have port uop_rd_en, output, 1: micro-op SRAM read strobe.
REQ-011 SHALL have port uop_rd_addr, output, 13: micro-op SRAM address.
REQ-012 SHALL have port uop_rd_data, input, 32: SRAM data, fixed 1-cycle latency after uop_rd_en.
REQ-013 SHALL have port out_valid, output, 1: index triple valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts triple.
REQ-015 SHALL have ports acc_idx and inp_idx, each output, 11: accumulator and input buffer index.
REQ-016 SHALL have port wgt_idx, output, 10: weight buffer index.

Function
REQ-017 Input accept (transfer) SHALL occur when in_valid && in_ready on a rising edge.
REQ-018 uop_rd_en SHALL equal in_valid && in_ready and uop_rd_addr SHALL equal upc, both combinational.
REQ-019 On transfer, stage-1 SHALL register s1_valid=1 plus the pre-summed offsets: dst_sum=dst_offset_out+dst_offset_in, src_sum=src_offset_out+src_offset_in, wgt_sum=wgt_offset_out+wgt_offset_in, each truncated to its field width.
REQ-020 With no transfer, s1_valid SHALL be 0 next cycle; stage 1 never stalls.
REQ-021 When s1_valid=1, the block SHALL form the triple from uop_rd_data and push it into the FIFO that same cycle.
REQ-022 Triple: acc_idx=uop_rd_data[10:0]+dst_sum mod 2^11.
REQ-023 Triple: inp_idx=uop_rd_data[21:11]+src_sum mod 2^11.
REQ-024 Triple: wgt_idx=uop_rd_data[31:22]+wgt_sum mod 2^10.
REQ-025 FIFO SHALL be 3 entries, in order.
REQ-026 out_valid SHALL equal (fifo_count!=0), with outputs driven from the head entry.
REQ-027 A pop SHALL occur when out_valid && out_ready.
REQ-028 Simultaneous push and pop SHALL leave fifo_count unchanged, including at count 3 and at count 0 (no fall-through; a pushed entry is visible next cycle).
REQ-029 in_ready SHALL equal (s1_valid + fifo_count) < 3, computed from registers only, with no combinational path from out_ready.
REQ-030 Latency SHALL be 2 cycles from transfer edge to out_valid=1.
REQ-031 Throughput SHALL be 1 triple/cycle when out_ready is held 1.
REQ-032 Push while fifo_count==3 without a pop SHALL be impossible by construction; the bench asserts it never happens.
REQ-033 Head outputs SHALL hold stable while out_valid && !out_ready.
REQ-034 clear=1 SHALL zero s1_valid and fifo_count next edge.
REQ-035 While clear=1, in_ready SHALL be 0 and uop_rd_en SHALL be 0.
REQ-036 clear SHALL take priority over a simultaneous push or pop.

Reset
REQ-037 rst=1 SHALL immediately force s1_valid=0, fifo_count=0, FIFO pointers=0, out_valid=0 and in_ready=0.
REQ-038 rst=1 SHALL force acc_idx, inp_idx and wgt_idx to 0.
REQ-039 The first rising edge after rst deasserts SHALL see in_ready=1.
REQ-040 rst asserted mid-operation SHALL discard all in-flight triples; none emerge after release.

Verification
REQ-041 Single op: upc=5, SRAM[5]={wgt=3,inp=7,acc=9}, dst offsets 16+2, src 32+1, wgt 4+0 -> 2 cycles later out_valid=1 with acc_idx=27, inp_idx=40, wgt_idx=7.
REQ-042 Wrap: acc field 2047, dst_offset_out=1, dst_offset_in=1 -> acc_idx=1; wgt field 1023, wgt_offset_in=2 -> wgt_idx=1.
REQ-043 Backpressure: out_ready=0, in_valid=1 every cycle -> exactly 3 accepts, then in_ready=0 with fifo_count=3; raise out_ready -> all triples emerge in order, with no loss or duplication.
REQ-044 Streaming: 100 back-to-back bundles with out_ready=1 -> 100 outputs on consecutive cycles, first at cycle 2 and in_ready never drops.
REQ-045 Clear with fifo_count=2, s1_valid=1 and simultaneous pop -> next cycle out_valid=0, in_ready=1, and no stale triple appears later.
REQ-046 rst pulse while 3 triples are pending -> out_valid=0 immediately, in_ready=0 during rst, and the first post-reset bundle returns the correct indices.
